kong_barrel_thrower: RTL and testbench
======================================

KONG_BARREL_THROWER -- requirements
Module: kong_barrel_thrower

Interface
REQ-001 Parameter THROW_PERIOD, default 65_000_000, meaning: cycles spent in ST_WAIT between throws.
REQ-002 Parameter ANIM_CYCLES, default 16_250_000, meaning: cycles spent in the windup animation before a spawn.
REQ-003 Parameter HAND_OFFSET, default 32, meaning: x offset from kong_xpos to the barrel spawn point.
REQ-004 Reset rst is synchronous and active-high; the clock is clk.
REQ-005 Port clk, input, 1 bit: system clock.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port start_game, input, 1 bit: game running; low forces the idle state.
REQ-008 Port kong_xpos, input, 11 bits: Kong x position from the movement block.
REQ-009 Port kong_ypos, input, 11 bits: Kong y position from the movement block.
REQ-010 Port barrel_free, input, 4 bits: bit i high means barrel slot i is unused.
REQ-011 Port animation, output, 1 bit: throw in progress; fed back to the movement block to freeze Kong.
REQ-012 Port spawn_valid, output, 4 bits: one-hot, one-cycle pulse selecting the slot to launch.
REQ-013 Port spawn_xpos, output, 11 bits: spawn x, valid while spawn_valid is nonzero.
REQ-014 Port spawn_ypos, output, 11 bits: spawn y, valid while spawn_valid is nonzero.
REQ-015 Port throw_count, output, 8 bits: total barrels spawned since reset.

Function
REQ-016 The FSM SHALL have exactly these states: ST_IDLE, ST_WAIT, ST_WINDUP, ST_BLOCKED, ST_SPAWN.
REQ-017 ST_IDLE SHALL go to ST_WAIT on the cycle after start_game is sampled high, with the cycle counter at 0.
REQ-018 In ST_WAIT the counter SHALL increment each cycle; at counter == THROW_PERIOD-1 the FSM SHALL go to ST_WINDUP and clear the counter.
REQ-019 In ST_WINDUP the counter SHALL increment each cycle; at counter == ANIM_CYCLES-1 the FSM SHALL exit.
REQ-020 On that exit, the FSM SHALL go to ST_SPAWN if barrel_free != 0, else to ST_BLOCKED.
REQ-021 ST_BLOCKED SHALL hold until barrel_free != 0, then go to ST_SPAWN.
REQ-022 ST_SPAWN SHALL last exactly one cycle and then go to ST_WAIT with the counter at 0.
REQ-023 animation SHALL be high exactly while the state is ST_WINDUP or ST_BLOCKED, and SHALL be decoded from the state register (no combinational input path).
REQ-024 On the transition into ST_SPAWN, the block SHALL latch the slot as the lowest-index set bit of barrel_free.
REQ-025 On the same transition, the block SHALL latch spawn_xpos = (kong_xpos + HAND_OFFSET) truncated to 11 bits, and spawn_ypos = kong_ypos.
REQ-026 spawn_valid SHALL equal the latched one-hot slot only while in ST_SPAWN, and SHALL be 0 otherwise.
REQ-027 spawn_xpos and spawn_ypos SHALL hold their last latched values outside ST_SPAWN.
REQ-028 throw_count SHALL increment by 1 in each ST_SPAWN cycle, saturate at 255, and be cleared only by rst.
REQ-029 If start_game is low in any state except ST_IDLE, the next state SHALL be ST_IDLE with the counter at 0 and no spawn.
REQ-030 REQ-029 applies even in ST_SPAWN: spawn_valid is still asserted for that current cycle, because it is decoded from the registered state.
REQ-031 Changes to barrel_free during ST_WAIT or ST_WINDUP SHALL have no effect; barrel_free is sampled only at the REQ-020/REQ-021 decision.
REQ-032 The counter SHALL be 27 bits wide, and both parameters SHALL be >= 1.

Reset
REQ-033 On rst the block SHALL set: state ST_IDLE, counter 0, animation 0, spawn_valid 0, spawn_xpos 0, spawn_ypos 0, throw_count 0.
REQ-034 rst SHALL take priority over all other inputs, and rst mid-windup SHALL drop animation on the next cycle.

Verification (THROW_PERIOD=10, ANIM_CYCLES=4, HAND_OFFSET=32)
REQ-035 Basic throw: start_game high from cycle 0, barrel_free=4'b1111, kong_xpos=300, kong_ypos=100 -> animation high in cycles 11-14; spawn_valid=4'b0001 in cycle 15; spawn_xpos=332, spawn_ypos=100; throw_count=1.
REQ-036 Slot priority: barrel_free=4'b1010 at the windup exit -> spawn_valid=4'b0010.
REQ-037 Blocked: barrel_free=0 at the windup exit, set to 4'b0100 five cycles later -> animation stays high through the wait; spawn_valid=4'b0100 on the cycle after barrel_free goes nonzero.
REQ-038 Abort: start_game dropped in cycle 12 (mid-windup) -> animation 0 from cycle 13; no spawn_valid pulse; throw_count unchanged.
REQ-039 Periodicity and saturation: run 300 throws with all slots free -> consecutive spawn pulses exactly 15 cycles apart; throw_count stops at 255.
REQ-040 Reset: rst asserted in ST_BLOCKED -> all outputs at their REQ-033 values on the next cycle.

Source files
------------

// File: rtl/kong_barrel_thrower.sv
// ============================================================================
//  Module   : kong_barrel_thrower
//  Brief    : Periodic Kong barrel thrower: wait, windup animation, slot pick, spawn.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module kong_barrel_thrower #(
  parameter int THROW_PERIOD = 65_000_000,
  parameter int ANIM_CYCLES  = 16_250_000,
  parameter int HAND_OFFSET  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_game,
  input  logic [10:0] kong_xpos,
  input  logic [10:0] kong_ypos,
  input  logic [3:0]  barrel_free,
  output logic        animation,
  output logic [3:0]  spawn_valid,
  output logic [10:0] spawn_xpos,
  output logic [10:0] spawn_ypos,
  output logic [7:0]  throw_count
);

  localparam logic [26:0] WAIT_LAST  = 27'(THROW_PERIOD - 1);
  localparam logic [26:0] ANIM_LAST  = 27'(ANIM_CYCLES - 1);
  localparam logic [10:0] HAND_DX    = 11'(HAND_OFFSET);
  localparam logic [7:0]  COUNT_MAX  = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_WINDUP  = 3'd2,
    ST_BLOCKED = 3'd3,
    ST_SPAWN   = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [26:0] count, count_next;
  logic        load_spawn;
  logic [3:0]  slot;
  logic [3:0]  lowest_free;
  logic        any_free;

  // Isolate the lowest set bit: x & -x.
  assign lowest_free = barrel_free & (~barrel_free + 4'd1);
  assign any_free    = |barrel_free;

  always_comb begin
    state_next = state;
    count_next = count;
    load_spawn = 1'b0;
    if (!start_game) begin
      state_next = ST_IDLE;
      count_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_WAIT;
          count_next = '0;
        end
        ST_WAIT: begin
          if (count == WAIT_LAST) begin
            state_next = ST_WINDUP;
            count_next = '0;
          end else begin
            count_next = count + 27'd1;
          end
        end
        ST_WINDUP: begin
          if (count == ANIM_LAST) begin
            count_next = '0;
            if (any_free) begin
              state_next = ST_SPAWN;
              load_spawn = 1'b1;
            end else begin
              state_next = ST_BLOCKED;
            end
          end else begin
            count_next = count + 27'd1;
          end
        end
        ST_BLOCKED: begin
          if (any_free) begin
            state_next = ST_SPAWN;
            load_spawn = 1'b1;
          end
        end
        ST_SPAWN: begin
          state_next = ST_WAIT;
          count_next = '0;
        end
        default: begin
          state_next = ST_IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      slot        <= '0;
      spawn_xpos  <= '0;
      spawn_ypos  <= '0;
      throw_count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      // Launch point is captured at the decision so Kong's motion later cannot skew it.
      if (load_spawn) begin
        slot       <= lowest_free;
        spawn_xpos <= kong_xpos + HAND_DX;
        spawn_ypos <= kong_ypos;
      end
      if (state == ST_SPAWN && throw_count != COUNT_MAX) begin
        throw_count <= throw_count + 8'd1;
      end
    end
  end

  // Outputs decode the registered state only, so the movement feedback loop stays registered.
  assign animation   = (state == ST_WINDUP) || (state == ST_BLOCKED);
  assign spawn_valid = (state == ST_SPAWN) ? slot : 4'b0000;

endmodule

`default_nettype wire

// File: tb/tb_kong_barrel_thrower.sv
// ============================================================================
//  Module   : tb_kong_barrel_thrower
//  Brief    : Directed self-checking bench for kong_barrel_thrower (10/4/32 config).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_kong_barrel_thrower;

  logic        clk;
  logic        rst;
  logic        start_game;
  logic [10:0] kong_xpos;
  logic [10:0] kong_ypos;
  logic [3:0]  barrel_free;
  logic        animation;
  logic [3:0]  spawn_valid;
  logic [10:0] spawn_xpos;
  logic [10:0] spawn_ypos;
  logic [7:0]  throw_count;

  int checks = 0;
  int errors = 0;

  kong_barrel_thrower #(
    .THROW_PERIOD (10),
    .ANIM_CYCLES  (4),
    .HAND_OFFSET  (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_game  (start_game),
    .kong_xpos   (kong_xpos),
    .kong_ypos   (kong_ypos),
    .barrel_free (barrel_free),
    .animation   (animation),
    .spawn_valid (spawn_valid),
    .spawn_xpos  (spawn_xpos),
    .spawn_ypos  (spawn_ypos),
    .throw_count (throw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: DUT in reset state, rst low, start_game high.
  task automatic start_run(input logic [3:0] bf, input logic [10:0] x, input logic [10:0] y);
    rst         = 1'b1;
    start_game  = 1'b0;
    barrel_free = bf;
    kong_xpos   = x;
    kong_ypos   = y;
    tick();
    tick();
    rst        = 1'b0;
    start_game = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_anim"},  32'(animation),   32'd0);
    check({tag, "_valid"}, 32'(spawn_valid), 32'd0);
    check({tag, "_x"},     32'(spawn_xpos),  32'd0);
    check({tag, "_y"},     32'(spawn_ypos),  32'd0);
    check({tag, "_cnt"},   32'(throw_count), 32'd0);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    int cyc;

    rst = 1'b1; start_game = 1'b0; barrel_free = '0; kong_xpos = '0; kong_ypos = '0;

    // Basic throw: windup in 11..14, spawn in 15.
    start_run(4'b1111, 11'd300, 11'd100);
    check_zero_outputs("reset");
    for (int c = 0; c <= 16; c++) begin
      check($sformatf("basic_anim_c%0d", c), 32'(animation), 32'((c >= 11 && c <= 14) ? 1 : 0));
      check($sformatf("basic_valid_c%0d", c), 32'(spawn_valid), 32'((c == 15) ? 4'b0001 : 4'b0000));
      if (c == 15) begin
        check("basic_x", 32'(spawn_xpos), 32'd332);
        check("basic_y", 32'(spawn_ypos), 32'd100);
      end
      if (c == 16) check("basic_cnt", 32'(throw_count), 32'd1);
      tick();
    end

    // Slot priority, barrel_free ignored during wait, x wraps at 11 bits.
    start_run(4'b1111, 11'd2040, 11'd7);
    for (int c = 0; c <= 15; c++) begin
      if (c == 5)  barrel_free = 4'b0000;
      if (c == 14) begin
        check("prio_anim_c14", 32'(animation), 32'd1);
        barrel_free = 4'b1010;
      end
      if (c == 15) begin
        check("prio_valid", 32'(spawn_valid), 32'(4'b0010));
        check("prio_x_wrap", 32'(spawn_xpos), 32'd24);
        check("prio_y", 32'(spawn_ypos), 32'd7);
      end
      tick();
    end

    // Blocked, then release; later reset while blocked.
    start_run(4'b0000, 11'd300, 11'd100);
    for (int c = 0; c <= 37; c++) begin
      if (c >= 15 && c <= 19) begin
        check($sformatf("blk_anim_c%0d", c), 32'(animation), 32'd1);
        check($sformatf("blk_valid_c%0d", c), 32'(spawn_valid), 32'd0);
      end
      if (c == 19) barrel_free = 4'b0100;
      if (c == 20) begin
        check("blk_valid_rel", 32'(spawn_valid), 32'(4'b0100));
        check("blk_anim_rel", 32'(animation), 32'd0);
      end
      if (c == 21) barrel_free = 4'b0000;
      if (c == 35) check("blk2_anim", 32'(animation), 32'd1);
      if (c == 36) begin
        check("blk2_cnt_pre", 32'(throw_count), 32'd1);
        check("blk2_x_pre", 32'(spawn_xpos), 32'd332);
        rst = 1'b1;
      end
      if (c == 37) check_zero_outputs("rst_blocked");
      tick();
    end
    rst = 1'b0;

    // Abort mid-windup.
    start_run(4'b1111, 11'd300, 11'd100);
    for (int c = 0; c <= 30; c++) begin
      if (c == 12) begin
        check("abort_anim_c12", 32'(animation), 32'd1);
        start_game = 1'b0;
      end
      if (c >= 13) begin
        check($sformatf("abort_anim_c%0d", c), 32'(animation), 32'd0);
        check($sformatf("abort_valid_c%0d", c), 32'(spawn_valid), 32'd0);
      end
      tick();
    end
    check("abort_cnt", 32'(throw_count), 32'd0);

    // Periodicity and saturation over 300 throws.
    start_run(4'b1111, 11'd300, 11'd100);
    pulses = 0;
    last_pulse = 0;
    cyc = 0;
    while (pulses < 300 && cyc < 300 * 15 + 50) begin
      if (spawn_valid != 4'b0000) begin
        check($sformatf("per_gap_%0d", pulses), 32'(cyc - last_pulse), 32'd15);
        check($sformatf("per_slot_%0d", pulses), 32'(spawn_valid), 32'(4'b0001));
        check($sformatf("per_cnt_%0d", pulses), 32'(throw_count), 32'((pulses > 255) ? 255 : pulses));
        last_pulse = cyc;
        pulses++;
      end
      tick();
      cyc++;
    end
    check("per_pulses", 32'(pulses), 32'd300);
    check("per_sat", 32'(throw_count), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
